// File: rtl/lsu_axi_master.sv
// lsu_axi_master
//   Load/store back end. Takes one memory operation at a time from execute,
//   requests the shared AXI4 master port from the arbiter, issues a single-beat
//   read or write, and returns extended load data plus an error code to
//   write-back.
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   in_*                      upstream request (valid/ready, addr, wdata, op, size, unsigned)
//   out_*                     downstream response (valid/ready, rdata, err)
//   req, grant                bus arbiter handshake
//   ar*, r*, aw*, w*, b*      AXI4 master channels (single beat, INCR, len 0)
//
// state  | meaning
// IDLE   | ready for a new request
// REQ    | requesting the bus, waiting for grant
// AR     | read address valid, waiting for arready
// R      | waiting for read data
// AW_W   | write address and write data outstanding
// B      | waiting for write response
// RESP   | response presented to write-back

module lsu_axi_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int AXI_ID     = 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ADDR_WIDTH-1:0]   in_addr,
    input  logic [DATA_WIDTH-1:0]   in_wdata,
    input  logic                    in_read,
    input  logic                    in_write,
    input  logic [1:0]              in_size,
    input  logic                    in_unsigned,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_rdata,
    output logic [1:0]              out_err,
    output logic                    req,
    input  logic                    grant,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic [3:0]              arid,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic [3:0]              rid,
    input  logic                    rvalid,
    output logic                    rready,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [3:0]              awid,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [1:0]              bresp,
    input  logic [3:0]              bid,
    input  logic                    bvalid,
    output logic                    bready
);
    localparam int         STRB_W   = DATA_WIDTH / 8;
    localparam int         OFF_W    = $clog2(STRB_W);
    localparam logic [1:0] MAX_SIZE = 2'(OFF_W);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_AR   = 3'd2;
    localparam logic [2:0] S_R    = 3'd3;
    localparam logic [2:0] S_AW_W = 3'd4;
    localparam logic [2:0] S_B    = 3'd5;
    localparam logic [2:0] S_RESP = 3'd6;

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            size_q;
    logic [1:0]            err_q;
    logic                  unsigned_q;
    logic                  read_q;
    logic                  aw_done;
    logic                  w_done;
    logic [OFF_W-1:0]      off_q;

    assign off_q = addr_q[OFF_W-1:0];

    // Low address bits must be zero for the access size; sizes wider than
    // the bus are trapped the same way.
    logic [2:0] align_mask;
    logic       bad_align;
    always_comb begin
        align_mask = (3'd1 << in_size) - 3'd1;
        bad_align  = (|(in_addr[2:0] & align_mask)) || (in_size > MAX_SIZE);
    end

    // Load lane extraction: shift the addressed lane down, keep 8<<size bits,
    // and sign-extend from the top kept bit (mask MSB isolated by mask^(mask>>1)).
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] lane_mask;
    logic [DATA_WIDTH-1:0] load_ext;
    logic                  lane_sign;
    always_comb begin
        shifted   = rdata >> {off_q, 3'b000};
        lane_mask = (DATA_WIDTH'(1) << (32'd8 << size_q)) - DATA_WIDTH'(1);
        lane_sign = |(shifted & (lane_mask ^ (lane_mask >> 1)));
        load_ext  = (shifted & lane_mask) | ((lane_sign && !unsigned_q) ? ~lane_mask : '0);
    end

    // Store data is replicated across every lane of its size so the strobes
    // alone select the target bytes.
    logic [DATA_WIDTH-1:0] wdata_rep;
    logic [STRB_W-1:0]     strb_base;
    always_comb begin
        case (size_q)
            2'd0:    wdata_rep = {STRB_W{wdata_q[7:0]}};
            2'd1:    wdata_rep = {(DATA_WIDTH/16){wdata_q[15:0]}};
            2'd2:    wdata_rep = {(DATA_WIDTH/32){wdata_q[31:0]}};
            default: wdata_rep = wdata_q;
        endcase
        strb_base = (STRB_W'(1) << (32'd1 << size_q)) - STRB_W'(1);
    end

    assign in_ready  = (state == S_IDLE);
    assign req       = (state == S_REQ) || (state == S_AR) || (state == S_R) ||
                       (state == S_AW_W) || (state == S_B);
    assign out_valid = (state == S_RESP);
    assign out_rdata = rdata_q;
    assign out_err   = err_q;

    assign arvalid = (state == S_AR);
    assign araddr  = addr_q;
    assign arid    = 4'(AXI_ID);
    assign arlen   = 8'd0;
    assign arsize  = {1'b0, size_q};
    assign arburst = 2'b01;
    assign rready  = (state == S_R);

    assign awvalid = (state == S_AW_W) && !aw_done;
    assign awaddr  = addr_q;
    assign awid    = 4'(AXI_ID);
    assign awlen   = 8'd0;
    assign awsize  = {1'b0, size_q};
    assign awburst = 2'b01;
    assign wvalid  = (state == S_AW_W) && !w_done;
    assign wdata   = wdata_rep;
    assign wstrb   = wvalid ? (strb_base << off_q) : '0;
    assign wlast   = wvalid;
    assign bready  = (state == S_B);

    logic unused_axi;
    assign unused_axi = ^{rid, rlast, rresp[0], bid, bresp[0]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            size_q     <= 2'd0;
            err_q      <= 2'b00;
            unsigned_q <= 1'b0;
            read_q     <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    addr_q     <= in_addr;
                    wdata_q    <= in_wdata;
                    size_q     <= in_size;
                    unsigned_q <= in_unsigned;
                    read_q     <= in_read;   // read wins if both are set
                    rdata_q    <= '0;
                    err_q      <= 2'b00;
                    aw_done    <= 1'b0;
                    w_done     <= 1'b0;
                    if (!in_read && !in_write) begin
                        state <= S_RESP;
                    end else if (bad_align) begin
                        err_q <= 2'b01;
                        state <= S_RESP;
                    end else begin
                        state <= S_REQ;
                    end
                end
                S_REQ: if (grant) state <= read_q ? S_AR : S_AW_W;
                S_AR:  if (arready) state <= S_R;
                S_R: if (rvalid) begin
                    rdata_q <= load_ext;
                    err_q   <= rresp[1] ? 2'b10 : 2'b00;
                    state   <= S_RESP;
                end
                S_AW_W: begin
                    if (awvalid && awready) aw_done <= 1'b1;
                    if (wvalid && wready)   w_done  <= 1'b1;
                    if ((aw_done || awready) && (w_done || wready)) state <= S_B;
                end
                S_B: if (bvalid) begin
                    err_q <= bresp[1] ? 2'b10 : 2'b00;
                    state <= S_RESP;
                end
                S_RESP:  if (out_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed bench for lsu_axi_master (DATA_WIDTH=32). The bench plays the
// arbiter, AXI slave and write-back stage; inputs change and outputs are
// sampled 1 time unit after each rising clock edge.

module tb_lsu_axi_master;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 0, in_ready, in_read = 0, in_write = 0, in_unsigned = 0;
    logic [31:0] in_addr = '0, in_wdata = '0;
    logic [1:0]  in_size = '0;
    logic        out_valid, out_ready = 0;
    logic [31:0] out_rdata;
    logic [1:0]  out_err;
    logic        req, grant = 0;
    logic [31:0] araddr, awaddr, wdata;
    logic [31:0] rdata = '0;
    logic [3:0]  arid, awid, wstrb;
    logic [3:0]  rid = '0, bid = '0;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst;
    logic [1:0]  rresp = '0, bresp = '0;
    logic        arvalid, arready = 0, rlast = 0, rvalid = 0, rready;
    logic        awvalid, awready = 0, wlast, wvalid, wready = 0, bvalid = 0, bready;

    int checks = 0;
    int errors = 0;
    int lat_cnt = 0;

    always #5 clk = ~clk;

    lsu_axi_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .AXI_ID(1)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_wdata(in_wdata),
        .in_read(in_read), .in_write(in_write), .in_size(in_size), .in_unsigned(in_unsigned),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err),
        .req(req), .grant(grant),
        .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awid(awid), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bid(bid), .bvalid(bvalid), .bready(bready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        lat_cnt++;
    endtask

    // Drives one load through the bench-side arbiter/slave and reports what it saw.
    task automatic run_load(input logic [31:0] a, input logic [1:0] sz, input logic uns,
                            input logic [31:0] rd, input logic [1:0] rr, input int hold,
                            output logic [31:0] o_araddr, output logic [2:0] o_arsize,
                            output logic [31:0] o_rdata, output logic [1:0] o_err,
                            output int o_lat, output bit o_to, output bit o_stable);
        int n;
        o_to = 0; o_stable = 1;
        in_valid = 1; in_addr = a; in_read = 1; in_write = 0; in_size = sz; in_unsigned = uns;
        tick();
        in_valid = 0; in_read = 0; lat_cnt = 0;
        grant = 1;
        n = 0;
        while (!arvalid && n < 20) begin tick(); n++; end
        grant = 0;
        if (!arvalid) o_to = 1;
        o_araddr = araddr; o_arsize = arsize;
        arready = 1; tick(); arready = 0;
        n = 0;
        while (!rready && n < 20) begin tick(); n++; end
        if (!rready) o_to = 1;
        rvalid = 1; rdata = rd; rresp = rr; tick(); rvalid = 0; rdata = '0; rresp = '0;
        n = 0;
        while (!out_valid && n < 20) begin tick(); n++; end
        if (!out_valid) o_to = 1;
        o_lat = lat_cnt; o_rdata = out_rdata; o_err = out_err;
        repeat (hold) begin
            tick();
            if (!out_valid || out_rdata !== o_rdata || out_err !== o_err || rready || arvalid) o_stable = 0;
        end
        out_ready = 1; tick(); out_ready = 0;
    endtask

    // Drives one store; skew=1 gives wready three cycles ahead of awready.
    task automatic run_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd,
                             input bit skew, input logic [1:0] br,
                             output logic [31:0] o_wdata, output logic [3:0] o_wstrb,
                             output logic [2:0] o_awsize, output logic [31:0] o_awaddr,
                             output logic [31:0] o_rdata, output logic [1:0] o_err,
                             output int o_bh, output bit o_order, output bit o_to);
        int n;
        o_to = 0; o_bh = 0;
        in_valid = 1; in_addr = a; in_write = 1; in_read = 0; in_size = sz; in_wdata = wd;
        tick();
        in_valid = 0; in_write = 0;
        grant = 1;
        n = 0;
        while (!awvalid && n < 20) begin tick(); n++; end
        grant = 0;
        if (!awvalid) o_to = 1;
        o_wdata = wdata; o_wstrb = wstrb; o_awsize = awsize; o_awaddr = awaddr;
        o_order = wvalid && wlast && awvalid && !bready;
        if (skew) begin
            wready = 1; tick(); wready = 0;
            repeat (2) begin
                if (wvalid || !awvalid || bready || awaddr !== o_awaddr) o_order = 0;
                tick();
            end
            if (wvalid || !awvalid || bready || awaddr !== o_awaddr) o_order = 0;
            awready = 1; tick(); awready = 0;
        end else begin
            awready = 1; wready = 1; tick(); awready = 0; wready = 0;
        end
        if (awvalid || wvalid) o_order = 0;
        n = 0;
        while (!bready && n < 20) begin tick(); n++; end
        if (!bready) o_to = 1;
        bvalid = 1; bresp = br;
        repeat (2) begin
            if (bready) o_bh++;
            tick();
        end
        bvalid = 0; bresp = '0;
        n = 0;
        while (!out_valid && n < 20) begin tick(); n++; end
        if (!out_valid) o_to = 1;
        o_rdata = out_rdata; o_err = out_err;
        out_ready = 1; tick(); out_ready = 0;
    endtask

    task automatic test_reset();
        rstn = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, req, arvalid, awvalid, wvalid, wlast, rready, bready} !== 9'b100000000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want %b",
                     {in_ready, out_valid, req, arvalid, awvalid, wvalid, wlast, rready, bready}, 9'b100000000);
        end
        checks++;
        if ({arid, awid, arlen, awlen, arburst, awburst} !== {4'd1, 4'd1, 8'd0, 8'd0, 2'b01, 2'b01}) begin
            errors++;
            $display("FAIL reset_const: got %h want %h", {arid, awid, arlen, awlen, arburst, awburst},
                     {4'd1, 4'd1, 8'd0, 8'd0, 2'b01, 2'b01});
        end
        checks++;
        if ({out_rdata, araddr, awaddr, wdata, wstrb, out_err, arsize, awsize} !== 140'd0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", {out_rdata, araddr, awaddr, wdata, wstrb, out_err, arsize, awsize});
        end
        rstn = 1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] rd;
        logic [31:0] exp;
    } ld_vec_t;

    task automatic test_loads();
        ld_vec_t lv [7];
        logic [31:0] o_araddr, o_rdata;
        logic [2:0]  o_arsize;
        logic [1:0]  o_err;
        int          o_lat;
        bit          o_to, o_st;
        lv = '{'{32'h8000_0003, 2'd0, 1'b0, 32'h80FF_1234, 32'hFFFF_FF80},
               '{32'h8000_0003, 2'd0, 1'b1, 32'h80FF_1234, 32'h0000_0080},
               '{32'h8000_0002, 2'd1, 1'b0, 32'h80FF_1234, 32'hFFFF_80FF},
               '{32'h8000_0002, 2'd1, 1'b1, 32'h80FF_1234, 32'h0000_80FF},
               '{32'h8000_0000, 2'd1, 1'b0, 32'h0000_7FFE, 32'h0000_7FFE},
               '{32'h8000_0004, 2'd2, 1'b0, 32'h1234_5678, 32'h1234_5678},
               '{32'h8000_0001, 2'd0, 1'b0, 32'h0000_FF00, 32'hFFFF_FFFF}};
        for (int i = 0; i < 7; i++) begin
            run_load(lv[i].a, lv[i].sz, lv[i].uns, lv[i].rd, 2'b00, 0,
                     o_araddr, o_arsize, o_rdata, o_err, o_lat, o_to, o_st);
            checks++;
            if (o_to) begin errors++; $display("FAIL load%0d_timeout: got timeout want handshakes", i); end
            checks++;
            if (o_araddr !== lv[i].a || o_arsize !== {1'b0, lv[i].sz}) begin
                errors++;
                $display("FAIL load%0d_ar: got addr %h size %0d want addr %h size %0d", i, o_araddr, o_arsize, lv[i].a, lv[i].sz);
            end
            checks++;
            if (o_rdata !== lv[i].exp || o_err !== 2'b00) begin
                errors++;
                $display("FAIL load%0d_data: got %h err %b want %h err 00", i, o_rdata, o_err, lv[i].exp);
            end
            checks++;
            if (o_lat !== 3) begin errors++; $display("FAIL load%0d_latency: got %0d want 3", i, o_lat); end
        end
    endtask

    task automatic test_bus_error();
        logic [31:0] o_araddr, o_rdata, o_wd, o_aw;
        logic [2:0]  o_arsize, o_aws;
        logic [3:0]  o_strb;
        logic [1:0]  o_err;
        int          o_lat, o_bh;
        bit          o_to, o_st, o_ord;
        run_load(32'h8000_0008, 2'd2, 1'b0, 32'hDEAD_BEEF, 2'b10, 0,
                 o_araddr, o_arsize, o_rdata, o_err, o_lat, o_to, o_st);
        checks++;
        if (o_err !== 2'b10 || o_to) begin errors++; $display("FAIL rd_buserr: got err %b to %0d want err 10", o_err, o_to); end
        run_load(32'h8000_0008, 2'd2, 1'b0, 32'h0BAD_F00D, 2'b01, 0,
                 o_araddr, o_arsize, o_rdata, o_err, o_lat, o_to, o_st);
        checks++;
        if (o_err !== 2'b00 || o_rdata !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL rd_exokay: got err %b data %h want err 00 data 0badf00d", o_err, o_rdata);
        end
        run_store(32'h8000_0001, 2'd0, 32'h0000_00A5, 1'b0, 2'b11,
                  o_wd, o_strb, o_aws, o_aw, o_rdata, o_err, o_bh, o_ord, o_to);
        checks++;
        if (o_wd !== 32'hA5A5_A5A5 || o_strb !== 4'b0010 || o_aws !== 3'd0) begin
            errors++;
            $display("FAIL sb_beat: got wdata %h strb %b size %0d want a5a5a5a5 0010 0", o_wd, o_strb, o_aws);
        end
        checks++;
        if (o_err !== 2'b10 || o_to) begin errors++; $display("FAIL wr_buserr: got err %b to %0d want err 10", o_err, o_to); end
    endtask

    task automatic test_store(input bit skew);
        logic [31:0] o_wd, o_aw, o_rdata;
        logic [2:0]  o_aws;
        logic [3:0]  o_strb;
        logic [1:0]  o_err;
        int          o_bh;
        bit          o_ord, o_to;
        run_store(32'h8000_0002, 2'd1, 32'h0000_BEEF, skew, 2'b00,
                  o_wd, o_strb, o_aws, o_aw, o_rdata, o_err, o_bh, o_ord, o_to);
        checks++;
        if (o_to) begin errors++; $display("FAIL sh%0d_timeout: got timeout want handshakes", skew); end
        checks++;
        if (o_wd !== 32'hBEEF_BEEF || o_strb !== 4'b1100 || o_aws !== 3'd1 || o_aw !== 32'h8000_0002) begin
            errors++;
            $display("FAIL sh%0d_beat: got wdata %h strb %b size %0d addr %h want beefbeef 1100 1 80000002",
                     skew, o_wd, o_strb, o_aws, o_aw);
        end
        checks++;
        if (!o_ord) begin errors++; $display("FAIL sh%0d_aw_w_order: got order violation want wvalid drop, awvalid held, late bready", skew); end
        checks++;
        if (o_bh !== 1) begin errors++; $display("FAIL sh%0d_b_count: got %0d want 1", skew, o_bh); end
        checks++;
        if (o_rdata !== 32'd0 || o_err !== 2'b00) begin
            errors++;
            $display("FAIL sh%0d_resp: got data %h err %b want 0 00", skew, o_rdata, o_err);
        end
    endtask

    task automatic test_back_to_back_word_store();
        logic [31:0] o_wd, o_aw, o_rdata;
        logic [2:0]  o_aws;
        logic [3:0]  o_strb;
        logic [1:0]  o_err;
        int          o_bh;
        bit          o_ord, o_to;
        run_store(32'h8000_0004, 2'd2, 32'h1234_5678, 1'b0, 2'b00,
                  o_wd, o_strb, o_aws, o_aw, o_rdata, o_err, o_bh, o_ord, o_to);
        checks++;
        if (o_wd !== 32'h1234_5678 || o_strb !== 4'b1111 || o_aws !== 3'd2 || o_err !== 2'b00 || o_to) begin
            errors++;
            $display("FAIL sw_beat: got wdata %h strb %b size %0d err %b want 12345678 1111 2 00", o_wd, o_strb, o_aws, o_err);
        end
    endtask

    task automatic test_misaligned();
        in_valid = 1; in_addr = 32'h8000_0002; in_read = 1; in_size = 2'd2; in_unsigned = 0;
        tick();
        in_valid = 0; in_read = 0;
        checks++;
        if ({out_valid, out_err, req, arvalid, in_ready} !== 6'b1_01_000) begin
            errors++;
            $display("FAIL lw_misaligned: got valid/err/req/arvalid/in_ready %b want 101000",
                     {out_valid, out_err, req, arvalid, in_ready});
        end
        out_ready = 1; tick(); out_ready = 0;
        checks++;
        if ({in_ready, req, arvalid, out_valid} !== 4'b1000) begin
            errors++;
            $display("FAIL lw_misaligned_after: got %b want 1000", {in_ready, req, arvalid, out_valid});
        end
        in_valid = 1; in_addr = 32'h8000_0000; in_read = 1; in_size = 2'd3;
        tick();
        in_valid = 0; in_read = 0;
        checks++;
        if ({out_valid, out_err, req} !== 4'b1_01_0) begin
            errors++;
            $display("FAIL ld_oversize: got valid/err/req %b want 1010", {out_valid, out_err, req});
        end
        out_ready = 1; tick(); out_ready = 0;
    endtask

    task automatic test_nonmem();
        in_valid = 1; in_addr = 32'h8000_0001; in_read = 0; in_write = 0; in_size = 2'd2;
        tick();
        in_valid = 0;
        checks++;
        if ({out_valid, out_err, req} !== 4'b1_00_0 || out_rdata !== 32'd0) begin
            errors++;
            $display("FAIL nonmem: got valid/err/req %b data %h want 1000 data 0", {out_valid, out_err, req}, out_rdata);
        end
        out_ready = 1; tick(); out_ready = 0;
    endtask

    task automatic test_backpressure();
        logic [31:0] o_araddr, o_rdata;
        logic [2:0]  o_arsize;
        logic [1:0]  o_err;
        int          o_lat;
        bit          o_to, o_st;
        run_load(32'h8000_0002, 2'd1, 1'b1, 32'hA55A_0000, 2'b00, 5,
                 o_araddr, o_arsize, o_rdata, o_err, o_lat, o_to, o_st);
        checks++;
        if (!o_st || o_to) begin errors++; $display("FAIL backpressure_hold: got stable %0d to %0d want stable 1 to 0", o_st, o_to); end
        checks++;
        if (o_rdata !== 32'h0000_A55A) begin errors++; $display("FAIL backpressure_data: got %h want 0000a55a", o_rdata); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] o_araddr, o_rdata;
        logic [2:0]  o_arsize;
        logic [1:0]  o_err;
        int          o_lat, n;
        bit          o_to, o_st;
        in_valid = 1; in_addr = 32'h8000_0000; in_read = 1; in_size = 2'd2;
        tick();
        in_valid = 0; in_read = 0;
        grant = 1;
        n = 0;
        while (!arvalid && n < 20) begin tick(); n++; end
        grant = 0;
        arready = 1; tick(); arready = 0;
        checks++;
        if (rready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_r: got rready %b want 1", rready); end
        rstn = 0;
        #2;
        checks++;
        if ({in_ready, req, arvalid, rready, awvalid, wvalid, bready, out_valid} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL rst_mid_valids: got %b want 10000000",
                     {in_ready, req, arvalid, rready, awvalid, wvalid, bready, out_valid});
        end
        rstn = 1;
        tick();
        run_load(32'h8000_0000, 2'd2, 1'b0, 32'hCAFE_F00D, 2'b00, 0,
                 o_araddr, o_arsize, o_rdata, o_err, o_lat, o_to, o_st);
        checks++;
        if (o_rdata !== 32'hCAFE_F00D || o_lat !== 3 || o_to) begin
            errors++;
            $display("FAIL rst_mid_recover: got data %h lat %0d want cafef00d lat 3", o_rdata, o_lat);
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_misaligned();
        test_nonmem();
        test_store(1'b1);
        test_store(1'b0);
        test_back_to_back_word_store();
        test_bus_error();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
